// File: rtl/pong_pkg.sv
// pong_pkg: shared constants and types for the pong datapath.
//   - Screen geometry (SCREEN_W x SCREEN_H visible pixels).
//   - Default bar and ball dimensions.
//   - Coordinate width used by every rectangle compare in the top level.
//   - Paddle FSM state encoding (HOLD/UP/DOWN).
package pong_pkg;

    localparam int SCREEN_W       = 640;
    localparam int SCREEN_H       = 480;

    localparam int DEF_BAR_LENGTH = 180;
    localparam int DEF_BAR_WIDTH  = 20;
    localparam int DEF_BALL_SIZE  = 20;

    localparam int COORD_W        = 12;

    // Saturation point of the hold-frame counter used by the acceleration option.
    localparam int ACCEL_SAT      = 16;

    typedef enum logic [1:0] {
        PS_HOLD = 2'd0,
        PS_UP   = 2'd1,
        PS_DOWN = 2'd2
    } paddle_state_t;

endpackage

// File: rtl/button_debounce.sv
// button_debounce: conditions one raw active-low push-button.
//   A 2-flop synchroniser (reset to released) feeds an inverter so that
//   pressed reads as 1. A stability counter accepts the new level once it
//   has differed from the accepted level for DEBOUNCE consecutive cycles;
//   any return to the accepted level clears the counter.
// Ports:
//   i_clk      clock
//   i_rst_n    active-low async reset (already synchronised by the parent)
//   i_btn_n    raw button, active-low
//   o_pressed  debounced level, 1 = pressed
module button_debounce #(
    parameter int DEBOUNCE = 250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_pressed
);

    localparam int CNT_W = ($clog2(DEBOUNCE) > 0) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_accepted;
    logic [CNT_W-1:0] r_cnt;
    logic             w_level;

    assign w_level = ~r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_accepted <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            if (w_level == r_accepted) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // Level has been different for DEBOUNCE cycles: take it.
                r_accepted <= w_level;
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pressed = r_accepted;

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: player paddle controller for the pong top level.
//   Debounces the up/down buttons, runs a HOLD/UP/DOWN FSM every cycle and
//   moves the bar once per frame on the rising edge of in_animate, clamping
//   y1 to 0 .. SCREEN_H-BAR_LENGTH. Outputs bar corners in 12-bit coordinates.
//   Optional build macro PADDLE_ACCEL_EN: a hold-frame counter raises the
//   step to 2*SPEED after 8 frames of continuous motion and 3*SPEED at 16.
// Ports:
//   in_clock     system clock
//   in_reset     async active-low reset (synchronised deassertion inside)
//   in_btn_up    raw up button, active-low
//   in_btn_down  raw down button, active-low
//   in_animate   end-of-frame strobe
//   in_enable    1 = movement allowed
//   out_x1/x2    bar left/right edge (constant)
//   out_y1/y2    bar top/bottom edge
//   out_state    FSM state (0 HOLD, 1 UP, 2 DOWN)
//
// state   | meaning
// --------+--------------------------------------------
// HOLD    | no button, both buttons, or movement disabled
// UP      | only up pressed; y1 decreases on each frame
// DOWN    | only down pressed; y1 increases on each frame
module paddle_ctrl #(
    parameter int IX         = 10,
    parameter int IY         = 150,
    parameter int BAR_WIDTH  = pong_pkg::DEF_BAR_WIDTH,
    parameter int BAR_LENGTH = pong_pkg::DEF_BAR_LENGTH,
    parameter int SCREEN_H   = pong_pkg::SCREEN_H,
    parameter int SPEED      = 4,
    parameter int DEBOUNCE   = 250000
) (
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic        in_btn_up,
    input  logic        in_btn_down,
    input  logic        in_animate,
    input  logic        in_enable,
    output logic [11:0] out_x1,
    output logic [11:0] out_x2,
    output logic [11:0] out_y1,
    output logic [11:0] out_y2,
    output logic [1:0]  out_state
);

    import pong_pkg::*;

    if (BAR_LENGTH >= SCREEN_H) begin : g_bad_bar_length
        $error("paddle_ctrl: BAR_LENGTH must be smaller than SCREEN_H");
    end

    localparam logic [COORD_W-1:0] X1_C    = COORD_W'(IX);
    localparam logic [COORD_W-1:0] X2_C    = COORD_W'(IX + BAR_WIDTH);
    localparam logic [COORD_W-1:0] Y1_RST  = COORD_W'(IY);
    localparam logic [COORD_W-1:0] BAR_L_C = COORD_W'(BAR_LENGTH);
    localparam logic signed [12:0] Y1_MAX  = 13'(SCREEN_H - BAR_LENGTH);
    localparam logic signed [12:0] STEP1   = 13'(SPEED);

    // Reset: asserts asynchronously, released two clocks after in_reset rises.
    logic r_rst_meta;
    logic r_rst_sync;
    logic w_rst_n;

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    logic w_up;
    logic w_down;

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_dbnc_up (
        .i_clk     (in_clock),
        .i_rst_n   (w_rst_n),
        .i_btn_n   (in_btn_up),
        .o_pressed (w_up)
    );

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_dbnc_down (
        .i_clk     (in_clock),
        .i_rst_n   (w_rst_n),
        .i_btn_n   (in_btn_down),
        .o_pressed (w_down)
    );

    paddle_state_t        r_state;
    paddle_state_t        w_state_next;
    logic [COORD_W-1:0]   r_y1;
    logic [COORD_W-1:0]   r_y2;
    logic                 r_anim_d;
    logic                 w_anim_rise;
    logic signed [12:0]   w_step;
    logic signed [12:0]   w_y1_ext;
    logic signed [12:0]   w_y1_sum;
    logic [COORD_W-1:0]   w_y1_next;

    // A long in_animate pulse moves the bar only once.
    assign w_anim_rise = in_animate & ~r_anim_d;

    always_comb begin
        w_state_next = PS_HOLD;
        if (in_enable) begin
            if (w_up && !w_down) begin
                w_state_next = PS_UP;
            end else if (w_down && !w_up) begin
                w_state_next = PS_DOWN;
            end
        end
    end

`ifdef PADDLE_ACCEL_EN
    localparam logic signed [12:0] STEP2 = 13'(2 * SPEED);
    localparam logic signed [12:0] STEP3 = 13'(3 * SPEED);
    localparam logic [4:0]         CNT_SAT = 5'(ACCEL_SAT);

    logic [4:0] r_hold_cnt;

    always_comb begin
        if (r_hold_cnt >= CNT_SAT) begin
            w_step = STEP3;
        end else if (r_hold_cnt >= 5'd8) begin
            w_step = STEP2;
        end else begin
            w_step = STEP1;
        end
    end
`else
    assign w_step = STEP1;
`endif

    // Signed 13-bit arithmetic so moving up from y1 < step goes negative
    // and saturates to 0 instead of wrapping.
    assign w_y1_ext = $signed({1'b0, r_y1});

    always_comb begin
        w_y1_sum  = w_y1_ext;
        w_y1_next = r_y1;
        case (r_state)
            PS_UP: begin
                w_y1_sum = w_y1_ext - w_step;
                if (w_y1_sum[12]) begin
                    w_y1_next = '0;
                end else begin
                    w_y1_next = w_y1_sum[11:0];
                end
            end
            PS_DOWN: begin
                w_y1_sum = w_y1_ext + w_step;
                if (w_y1_sum > Y1_MAX) begin
                    w_y1_next = Y1_MAX[11:0];
                end else begin
                    w_y1_next = w_y1_sum[11:0];
                end
            end
            default: begin
                w_y1_sum  = w_y1_ext;
                w_y1_next = r_y1;
            end
        endcase
    end

    // Motion uses r_state as registered before the animate cycle, so a
    // button change landing on that cycle only affects the next frame.
    always_ff @(posedge in_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= PS_HOLD;
            r_y1     <= Y1_RST;
            r_y2     <= Y1_RST + BAR_L_C;
            r_anim_d <= 1'b0;
`ifdef PADDLE_ACCEL_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            r_anim_d <= in_animate;
            r_state  <= w_state_next;
            if (w_anim_rise) begin
                r_y1 <= w_y1_next;
                r_y2 <= w_y1_next + BAR_L_C;
            end
`ifdef PADDLE_ACCEL_EN
            // Any state change (into HOLD or reversing) restarts the count.
            if (r_state == PS_HOLD || w_state_next != r_state) begin
                r_hold_cnt <= '0;
            end else if (w_anim_rise && r_hold_cnt != CNT_SAT) begin
                r_hold_cnt <= r_hold_cnt + 5'd1;
            end
`endif
        end
    end

    assign out_x1    = X1_C;
    assign out_x2    = X2_C;
    assign out_y1    = r_y1;
    assign out_y2    = r_y2;
    assign out_state = r_state;

endmodule
